// File: rtl/mul_sequencer.sv
// Unsigned shift-add multiplier sequencer for the execute stage.
// One ripple adder is reused for WIDTH iterations, one bit per cycle.

module rippleAdder #(
    parameter int ADDER_SIZE = 8
) (
    input  logic [ADDER_SIZE-1:0] a,
    input  logic [ADDER_SIZE-1:0] b,
    output logic [ADDER_SIZE-1:0] sum,
    output logic                  overflow
);

    logic [ADDER_SIZE:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < ADDER_SIZE; i++) begin : gBit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    // Signed overflow; the multiplier works unsigned and ignores it.
    assign overflow = carry[ADDER_SIZE] ^ carry[ADDER_SIZE-1];

endmodule

module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   acc;
    logic [CW-1:0]      count;

    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH:0]     addSum;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH:0]   shifted;
    logic               addOvfUnused;
    logic               accTopUnused;

    assign hi = acc[2*WIDTH-1:WIDTH];
    assign lo = acc[WIDTH-1:0];

    // The carry bit of acc is always cleared by the shift.
    assign accTopUnused = acc[2*WIDTH];

    rippleAdder #(
        .ADDER_SIZE(WIDTH + 1)
    ) uAdder (
        .a       ({1'b0, hi}),
        .b       ({1'b0, mcand}),
        .sum     (addSum),
        .overflow(addOvfUnused)
    );

    assign partial = acc[0] ? addSum : {1'b0, hi};

    // {carry, hi, lo} shifted right by one, with carry landing in hi's MSB.
    assign shifted = {1'b0, partial, lo[WIDTH-1:1]};

    assign busy = (state == RUN);

    // Control FSM plus datapath registers; product latches on the last step.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= IDLE;
            done    <= 1'b0;
            product <= '0;
            count   <= '0;
            acc     <= '0;
            mcand   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= multiplicand;
                        acc   <= {1'b0, {WIDTH{1'b0}}, multiplier};
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= shifted;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        product <= shifted[2*WIDTH-1:0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer at WIDTH=32.
// Vector table plus hand-written reset, start-noise and back-to-back cases.

module tb_mul_sequencer;

    localparam int W = 32;

    logic          clk;
    logic          rstN;
    logic          start;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;

    int nCmp;
    int nBad;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] p;
    } vec_t;

    vec_t vecs[8];

    mul_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One operation: start sampled at edge 1, busy after edges 1..32,
    // done after edge 33 only. Optional noise on start/operands mid-op.
    task automatic runOp(input string name, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] exp,
                         input bit noisy);
        bit latOk;
        latOk = 1'b1;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        for (int e = 1; e <= 33; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                start        = 1'b0;
                multiplicand = ~a;
                multiplier   = ~b;
            end
            if (noisy && e == 4) begin
                start        = 1'b1;
                multiplicand = 32'h5;
                multiplier   = 32'h6;
            end
            if (noisy && e == 5) start = 1'b0;
            if (noisy && e == 32) begin
                start        = 1'b1;
                multiplicand = 32'hAAAA_0001;
                multiplier   = 32'h3;
            end
            if (e <= 32) begin
                if (!(busy === 1'b1 && done === 1'b0)) latOk = 1'b0;
            end else begin
                if (!(busy === 1'b0 && done === 1'b1)) latOk = 1'b0;
            end
        end
        check({name, "_latency"}, 64'(latOk), 64'd1);
        check({name, "_product"}, product, exp);
        @(posedge clk);
        #1;
        if (noisy) start = 1'b0;
        check({name, "_donePulse"}, 64'(done), 64'd0);
        check({name, "_hold"}, product, exp);
    endtask

    task automatic expectQuiet(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [W-1:0]   ra[3];
        logic [W-1:0]   rb[3];
        int             doneEdge[3];
        int             nDone;

        nCmp = 0;
        nBad = 0;

        vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h1234_5678,  32'd0,          64'h0};
        vecs[3] = '{32'd0,          32'hDEAD_BEEF,  64'h0};
        vecs[4] = '{32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
        vecs[5] = '{32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
        vecs[6] = '{32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
        vecs[7] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};

        rstN         = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", product, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 8; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, 1'b0);
        end

        runOp("noise", 32'd7, 32'd9, 64'd63, 1'b1);
        expectQuiet("noise_noSecondDone", 40);
        check("noise_productHeld", product, 64'd63);
        runOp("afterNoise", 32'd11, 32'd13, 64'd143, 1'b0);

        @(negedge clk);
        multiplicand = 32'h8000_0000;
        multiplier   = 32'd2;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        check("midReset_busy", 64'(busy), 64'd0);
        check("midReset_done", 64'(done), 64'd0);
        check("midReset_product", product, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        expectQuiet("midReset_noDone", 40);
        runOp("afterReset", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 1'b0);

        for (int k = 0; k < 3; k++) begin
            ra[k] = $urandom;
            rb[k] = $urandom;
            doneEdge[k] = -1;
        end
        nDone = 0;
        @(negedge clk);
        multiplicand = ra[0];
        multiplier   = rb[0];
        start        = 1'b1;
        for (int e = 1; e <= 120 && nDone < 3; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                doneEdge[nDone] = e;
                check($sformatf("b2b_product%0d", nDone), product,
                      64'(ra[nDone]) * 64'(rb[nDone]));
                nDone++;
                if (nDone < 3) begin
                    multiplicand = ra[nDone];
                    multiplier   = rb[nDone];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_doneCount", 64'(nDone), 64'd3);
        check("b2b_edge0", 64'(doneEdge[0]), 64'd33);
        check("b2b_edge1", 64'(doneEdge[1]), 64'd67);
        check("b2b_edge2", 64'(doneEdge[2]), 64'd101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
